// File: rtl/clk_en_pkg.sv
// clk_en_pkg - shared types and constants for the clock-enable generator.
//   state_t : sequencing FSM states (S_WAIT, S_HOLD, S_RUN)
//   FRACW   : fractional accumulator width (used only with CLKEN_FRAC_EN)
//   DEF_*   : default widths and counts used by the top-level parameters
package clk_en_pkg;

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_HOLD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  localparam int FRACW        = 8;
  localparam int DEF_NCH      = 4;
  localparam int DEF_DIVW     = 16;
  localparam int DEF_RST_HOLD = 16;

endpackage

// File: rtl/clk_en_chan.sv
// clk_en_chan - one enable channel: down-counter, active/shadow divide and
// phase, pending-update flag and (with CLKEN_FRAC_EN) a fractional accumulator.
// Ports:
//   clk, rst_n   fast clock, asynchronous active-low reset
//   i_run        top FSM is in S_RUN (counter runs, ce allowed)
//   i_load       phase load (S_RUN entry or sync)
//   i_flush      leaving S_RUN: pending shadow values become active
//   i_we         accepted config write addressed to this channel
//   i_div        new divide (0 behaves as 1)
//   i_phase      new phase offset
//   i_frac       new fractional divide (CLKEN_FRAC_EN only)
//   o_ce         one-cycle enable pulse
//   o_pending    shadow update waiting for the next terminal count
module clk_en_chan
  import clk_en_pkg::*;
#(
  parameter int              DIVW    = 16,
  parameter logic [DIVW-1:0] DIV_RST = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_run,
  input  logic            i_load,
  input  logic            i_flush,
  input  logic            i_we,
  input  logic [DIVW-1:0] i_div,
  input  logic [DIVW-1:0] i_phase,
`ifdef CLKEN_FRAC_EN
  input  logic [FRACW-1:0] i_frac,
`endif
  output logic            o_ce,
  output logic            o_pending
);

  // Reload value for a divide; 0 and 1 both give a period of one cycle.
  function automatic logic [DIVW-1:0] last_of(input logic [DIVW-1:0] d);
    return (d == '0) ? '0 : d - 1'b1;
  endfunction

  // Phase is saturated to the last count so the counter never exceeds div-1.
  function automatic logic [DIVW-1:0] clamp(input logic [DIVW-1:0] p,
                                            input logic [DIVW-1:0] lim);
    return (p > lim) ? lim : p;
  endfunction

  logic [DIVW-1:0] r_cnt, r_div, r_phase, r_sh_div, r_sh_phase;
  logic            r_pending;
  logic            w_tc, w_apply, w_direct, w_shadow;
  logic [DIVW-1:0] w_div_n, w_phase_n, w_last_n, w_reload;

  assign w_tc     = (r_cnt == '0);
  assign w_apply  = r_pending & (i_load | i_flush | (i_run & w_tc));
  // A write that lands on the cycle run ends goes straight to the active set.
  assign w_direct = i_we & (~i_run | i_flush);
  assign w_shadow = i_we & i_run & ~i_flush;

`ifdef CLKEN_FRAC_EN
  logic [FRACW-1:0] r_frac, r_sh_frac, r_acc, w_frac_n;
  logic [FRACW:0]   w_acc_sum;
`endif

  // Active values as they will be after this cycle's update; the reload and
  // phase load below already use them.
  always_comb begin
    w_div_n   = r_div;
    w_phase_n = r_phase;
`ifdef CLKEN_FRAC_EN
    w_frac_n  = r_frac;
`endif
    if (w_apply) begin
      w_div_n   = r_sh_div;
      w_phase_n = r_sh_phase;
`ifdef CLKEN_FRAC_EN
      w_frac_n  = r_sh_frac;
`endif
    end else if (w_direct) begin
      w_div_n   = i_div;
      w_phase_n = i_phase;
`ifdef CLKEN_FRAC_EN
      w_frac_n  = i_frac;
`endif
    end
  end

  assign w_last_n = last_of(w_div_n);

`ifdef CLKEN_FRAC_EN
  // Accumulator carry stretches the next period by one cycle.
  assign w_acc_sum = {1'b0, r_acc} + {1'b0, w_frac_n};
  assign w_reload  = w_last_n + {{(DIVW-1){1'b0}}, w_acc_sum[FRACW]};
`else
  assign w_reload  = w_last_n;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_div      <= DIV_RST;
      r_phase    <= '0;
      r_sh_div   <= DIV_RST;
      r_sh_phase <= '0;
      r_pending  <= 1'b0;
`ifdef CLKEN_FRAC_EN
      r_frac     <= '0;
      r_sh_frac  <= '0;
      r_acc      <= '0;
`endif
    end else begin
      r_div   <= w_div_n;
      r_phase <= w_phase_n;
`ifdef CLKEN_FRAC_EN
      r_frac  <= w_frac_n;
`endif
      if (w_shadow) begin
        r_sh_div   <= i_div;
        r_sh_phase <= i_phase;
`ifdef CLKEN_FRAC_EN
        r_sh_frac  <= i_frac;
`endif
        r_pending  <= 1'b1;
      end else if (w_apply) begin
        r_pending  <= 1'b0;
      end
      if (i_load) begin
        r_cnt <= clamp(w_phase_n, w_last_n);
`ifdef CLKEN_FRAC_EN
        r_acc <= '0;
`endif
      end else if (i_run) begin
        if (w_tc) begin
          r_cnt <= w_reload;
`ifdef CLKEN_FRAC_EN
          r_acc <= w_acc_sum[FRACW-1:0];
`endif
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end
  end

  assign o_ce      = i_run & w_tc;
  assign o_pending = r_pending;

endmodule

// File: rtl/clk_en_gen.sv
// clk_en_gen - multi-channel clock-enable generator on the PLL fast clock,
// with system reset sequencing from PLL lock.
// Optional feature macro: CLKEN_FRAC_EN adds cfg_frac and fractional periods.
// Ports:
//   clk          fast clock (PLL output)
//   rst_n        asynchronous active-low reset
//   pll_locked   PLL lock (asynchronous, 2-FF synchronised here)
//   cfg_we       config write strobe, accepted when cfg_ready is high
//   cfg_ch       target channel (values >= NCH are accepted and dropped)
//   cfg_div      new divide (0 behaves as 1)
//   cfg_phase    new phase offset
//   cfg_frac     new fractional divide (CLKEN_FRAC_EN only)
//   cfg_ready    no channel has a pending update
//   sync         realign all channels to their phase (ignored outside run)
//   ce           one-cycle enable pulses, one per channel
//   sys_rst_n    registered active-low system reset, high only in S_RUN
//   running      registered, high only in S_RUN
module clk_en_gen
  import clk_en_pkg::*;
#(
  parameter int                NCH      = DEF_NCH,
  parameter int                DIVW     = DEF_DIVW,
  parameter int                RST_HOLD = DEF_RST_HOLD,
  parameter logic [NCH*DIVW-1:0] DIV_INIT = {16'd8, 16'd2, 16'd1, 16'd1},
  localparam int               CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_locked,
  input  logic             cfg_we,
  input  logic [CHW-1:0]   cfg_ch,
  input  logic [DIVW-1:0]  cfg_div,
  input  logic [DIVW-1:0]  cfg_phase,
`ifdef CLKEN_FRAC_EN
  input  logic [FRACW-1:0] cfg_frac,
`endif
  output logic             cfg_ready,
  input  logic             sync,
  output logic [NCH-1:0]   ce,
  output logic             sys_rst_n,
  output logic             running
);

  localparam int            HW        = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);

  logic           r_lock_meta, r_lock_s;
  state_t         r_state, w_next;
  logic [HW-1:0]  r_hold;
  logic           r_sys_rst_n, r_running;
  logic           w_run, w_enter, w_flush, w_load, w_acc_we;
  logic [NCH-1:0] w_pending, w_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= pll_locked;
      r_lock_s    <= r_lock_meta;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_WAIT:  if (r_lock_s) w_next = S_HOLD;
      S_HOLD:  if (!r_lock_s) w_next = S_WAIT;
               else if (r_hold == HOLD_LAST) w_next = S_RUN;
      S_RUN:   if (!r_lock_s) w_next = S_WAIT;
      default: w_next = S_WAIT;
    endcase
  end

  // Status outputs are registered from the next state so they line up
  // exactly with r_state == S_RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_WAIT;
      r_hold      <= '0;
      r_sys_rst_n <= 1'b0;
      r_running   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_hold      <= (r_state == S_HOLD && w_next == S_HOLD) ? r_hold + 1'b1 : '0;
      r_sys_rst_n <= (w_next == S_RUN);
      r_running   <= (w_next == S_RUN);
    end
  end

  assign w_run   = (r_state == S_RUN);
  assign w_enter = (w_next == S_RUN) && !w_run;
  assign w_flush = w_run && (w_next != S_RUN);
  assign w_load  = w_enter | (sync & w_run & ~w_flush);

  assign cfg_ready = ~|w_pending;
  assign w_acc_we  = cfg_we & cfg_ready;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    assign w_we[gi] = w_acc_we & (cfg_ch == CHW'(gi));

    clk_en_chan #(
      .DIVW    (DIVW),
      .DIV_RST (DIV_INIT[gi*DIVW +: DIVW])
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_run     (w_run),
      .i_load    (w_load),
      .i_flush   (w_flush),
      .i_we      (w_we[gi]),
      .i_div     (cfg_div),
      .i_phase   (cfg_phase),
`ifdef CLKEN_FRAC_EN
      .i_frac    (cfg_frac),
`endif
      .o_ce      (ce[gi]),
      .o_pending (w_pending[gi])
    );
  end

  assign sys_rst_n = r_sys_rst_n;
  assign running   = r_running;

endmodule

// File: tb/tb_clk_en_gen.sv
module tb_clk_en_gen;
  localparam int NCH  = 4;
  localparam int DIVW = 16;

  logic            clk = 1'b0;
  logic            rst_n, pll_locked, cfg_we, sync;
  logic [1:0]      cfg_ch;
  logic [DIVW-1:0] cfg_div, cfg_phase;
  logic            cfg_ready, sys_rst_n, running;
  logic [NCH-1:0]  ce;
`ifdef CLKEN_FRAC_EN
  logic [7:0]      cfg_frac;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int rise_n;
  logic [3:0] ce_seen;

  always #5 clk = ~clk;

  clk_en_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_div    (cfg_div),
    .cfg_phase  (cfg_phase),
`ifdef CLKEN_FRAC_EN
    .cfg_frac   (cfg_frac),
`endif
    .cfg_ready  (cfg_ready),
    .sync       (sync),
    .ce         (ce),
    .sys_rst_n  (sys_rst_n),
    .running    (running)
  );

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic wait_ready();
    int k = 0;
    while (cfg_ready !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk_eq("cfg_ready_wait", 32'(cfg_ready), 32'd1);
  endtask

  task automatic cfg_write(input int ch, input int div, input int ph);
    wait_ready();
    cfg_we    = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_div   = DIVW'(div);
    cfg_phase = DIVW'(ph);
    @(negedge clk);
    cfg_we    = 1'b0;
  endtask

  // Counts posedges until sys_rst_n is seen high; ORs ce over the cycles before.
  task automatic measure_rise(output int n, output logic [3:0] seen);
    n = 0;
    seen = '0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (sys_rst_n === 1'b1) begin
        n = k;
        break;
      end
      seen |= ce;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; pll_locked = 1'b1; cfg_we = 1'b0; sync = 1'b0;
    cfg_ch = '0; cfg_div = '0; cfg_phase = '0;
`ifdef CLKEN_FRAC_EN
    cfg_frac = '0;
`endif
    repeat (3) @(negedge clk);
    chk_eq("rst_ce",        32'(ce),        32'd0);
    chk_eq("rst_sys_rst_n", 32'(sys_rst_n), 32'd0);
    chk_eq("rst_running",   32'(running),   32'd0);
    chk_eq("rst_cfg_ready", 32'(cfg_ready), 32'd1);

    // Release reset with lock already high: 2 sync + 16 hold + 1.
    rst_n = 1'b1;
    measure_rise(rise_n, ce_seen);
    chk_eq("rise_cycles",  32'(rise_n),  32'd19);
    chk_eq("ce_quiet_pre", 32'(ce_seen), 32'd0);
    chk_eq("running_rise", 32'(running), 32'd1);

    // Default divides 1,1,2,8, all phases 0.
    for (int k = 0; k < 16; k++) begin
      chk_eq("dflt_ce", 32'(ce), 32'({(k % 8 == 0), (k % 2 == 0), 1'b1, 1'b1}));
      @(negedge clk);
    end
    repeat (3) @(negedge clk);

    // Run cycle 19: ch3 div=5 while ch3 counter is mid-period.
    for (int c = 19; c <= 35; c++) begin
      if (c == 19) begin
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_div = 16'd5; cfg_phase = 16'd0;
      end else begin
        cfg_we = 1'b0;
      end
      chk_eq("wr_ch3_rdy_ce", 32'({cfg_ready, ce[3]}),
             32'({(c < 20 || c >= 25), (c == 24 || c == 29 || c == 34)}));
      @(negedge clk);
    end

    // Program phases, then realign with sync.
    cfg_write(2, 2, 1);
    cfg_write(3, 5, 3);
    wait_ready();
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      chk_eq("sync_ce32", 32'(ce[3:2]), 32'({(k == 4 || k == 9), (k >= 2 && k % 2 == 0)}));
      @(negedge clk);
    end

    // Lock loss: sys_rst_n and ce drop on the third edge.
    pll_locked = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_eq("drop_still_run", 32'({sys_rst_n, running}), 32'h3);
    @(negedge clk);
    chk_eq("drop_ce",        32'(ce),        32'd0);
    chk_eq("drop_sys_rst_n", 32'(sys_rst_n), 32'd0);
    chk_eq("drop_running",   32'(running),   32'd0);

    // Direct write while stopped: div=0 behaves as 1, phase clamps to 0.
    cfg_write(2, 0, 5);
    chk_eq("direct_ready", 32'(cfg_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk_eq("wait_ce", 32'(ce), 32'd0);
      @(negedge clk);
    end

    pll_locked = 1'b1;
    measure_rise(rise_n, ce_seen);
    chk_eq("relock_rise",  32'(rise_n),  32'd19);
    chk_eq("relock_quiet", 32'(ce_seen), 32'd0);
    for (int k = 0; k < 10; k++) begin
      chk_eq("relock_ce", 32'(ce), 32'({(k == 3 || k == 8), 1'b1, 1'b1, 1'b1}));
      @(negedge clk);
    end

`ifdef CLKEN_FRAC_EN
    begin
      int t, t0, t1, t2, pulses, span;
      wait_ready();
      cfg_we = 1'b1; cfg_ch = 2'd3; cfg_div = 16'd4; cfg_phase = 16'd0; cfg_frac = 8'd128;
      @(negedge clk);
      cfg_we = 1'b0; cfg_frac = 8'd0;
      wait_ready();
      sync = 1'b1;
      @(negedge clk);
      sync = 1'b0;
      t = 0; t0 = 0; t1 = 0; t2 = 0; pulses = 0; span = 0;
      while (t < 700 && pulses < 101) begin
        if (ce[3]) begin
          if (pulses == 0) t0 = t;
          if (pulses == 1) t1 = t;
          if (pulses == 2) t2 = t;
          pulses++;
          if (pulses == 101) span = t - t0;
        end
        t++;
        @(negedge clk);
      end
      chk_eq("frac_p1",   32'(t1 - t0), 32'd4);
      chk_eq("frac_p2",   32'(t2 - t1), 32'd5);
      chk_eq("frac_span", 32'(span),    32'd450);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
